// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED frame scheduler.
// The tap positions select which shift-register bits drive the three LED pins.
package led_sched_pkg;

    localparam int BYTE_W  = 8;
    localparam int CNT_W   = $clog2(BYTE_W);
    localparam int DWELL_W = 16;

    localparam int TAP_HI  = 7;
    localparam int TAP_MID = 3;
    localparam int TAP_LO  = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DWELL
    } sched_state_t;

    // Modular increment that wraps at n without relying on power-of-two overflow.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap
// and returns the first asserted request as a one-hot grant plus its index.
module rr_arbiter
    import led_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NREQ);

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'(wrap_add(int'(last_grant), k, NREQ));
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Shares one 8-bit LED shift register among NREQ byte requesters: arbitrate,
// shift the winning byte in MSB-first, latch three taps onto LED, then dwell.
module led_frame_scheduler
    import led_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BYTE_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [2:0]               LED,
    output logic [$clog2(NREQ)-1:0]  led_owner,
    output logic                     led_valid,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'((DWELL == 0) ? 0 : DWELL - 1);

    sched_state_t       state_q, state_d;
    logic [BYTE_W-1:0]  hold_q, hold_d;
    logic [BYTE_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [2:0]         led_q, led_d;
    logic [IDX_W-1:0]   led_owner_q, led_owner_d;
    logic               led_valid_q, led_valid_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               handshake;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // Grants only exist in IDLE and never while reset is held, so no byte is lost to reset.
    assign handshake = (state_q == S_IDLE) && !rst && (|arb_gnt);
    assign req_ready = handshake ? arb_gnt : '0;

    assign busy      = (state_q != S_IDLE) && !rst;
    assign LED       = rst ? 3'b000 : led_q;
    assign led_owner = rst ? '0 : led_owner_q;
    assign led_valid = led_valid_q && !rst;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        sr_d         = sr_q;
        bitcnt_d     = bitcnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        led_d        = led_q;
        led_owner_d  = led_owner_q;
        led_valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    hold_d       = req_data[{arb_idx, CNT_W'(0)} +: BYTE_W];
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    bitcnt_d     = '0;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d     = {sr_q[BYTE_W-2:0], hold_q[CNT_W'(BYTE_W-1) - bitcnt_q]};
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(BYTE_W-1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                led_d       = {sr_q[TAP_HI], sr_q[TAP_MID], sr_q[TAP_LO]};
                led_owner_d = grant_q;
                led_valid_d = 1'b1;
                dwell_cnt_d = '0;
                state_d     = (DWELL == 0) ? S_IDLE : S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt_q == DWELL_LAST) begin
                    dwell_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            sr_q         <= '0;
            bitcnt_q     <= '0;
            dwell_cnt_q  <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
            led_q        <= '0;
            led_owner_q  <= '0;
            led_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            sr_q         <= sr_d;
            bitcnt_q     <= bitcnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            led_q        <= led_d;
            led_owner_q  <= led_owner_d;
            led_valid_q  <= led_valid_d;
        end
    end

endmodule
